bit_count_arbiter: RTL and testbench
====================================

# bit_count_arbiter

Shares one bit-count (popcount) datapath between `REQ_N` requesters. Each requester offers a `WIDTH`-bit word with a valid/ready handshake. A round-robin arbiter picks one word at a time and passes it to a registered counting core. The result is returned on a single output channel, tagged with the requester ID and subject to back-pressure. The block sits in front of the counting datapath and replaces its bare `data_val_i` strobe with a fair, flow-controlled front end.

## Interface
- `WIDTH`, 8, bits per data word
- `REQ_N`, 4, number of requesters (≥2)
- `clk_i` input 1: single clock
- `srst_i` input 1: synchronous, active-high reset
- `req_val_i` input `REQ_N`: per-requester valid
- `req_data_i` input `REQ_N*WIDTH`: requester k in bits `[k*WIDTH +: WIDTH]`
- `req_rdy_o` output `REQ_N`: one-hot accept; the transfer happens when `req_val_i[k] & req_rdy_o[k]`
- `res_val_o` output 1: result valid
- `res_data_o` output `$clog2(WIDTH)+2`: number of ones in the accepted word; upper bits zero
- `res_id_o` output `$clog2(REQ_N)`: index of the requester the result belongs to
- `res_rdy_i` input 1: consumer accepts the result

## Operation
- FSM states: `IDLE`, `CALC`, `DONE`.
- `IDLE`
  - If any `req_val_i` is high, assert `req_rdy_o` (combinational) for the round-robin winner only.
  - Latch the winner's data and ID, then go to `CALC`.
  - If no request is present, stay in `IDLE` with `req_rdy_o` all zero.
- `CALC`: the core registers the popcount. Go to `DONE` unconditionally.
- `DONE`
  - `res_val_o`=1. `res_data_o` and `res_id_o` are held stable until `res_rdy_i`=1.
  - When `res_rdy_i`=1, go to `IDLE`.
  - `req_rdy_o` is all zero (unless `BIT_COUNT_ARB_B2B_EN`, see Configuration).
- Round-robin
  - Pointer `last` holds the most recently granted ID.
  - Search order is `last+1, last+2, …`, wrapping modulo `REQ_N`.
  - `last` updates only on an accepted transfer.
- Requesters hold `req_val_i` and data stable until accepted. Dropping a request before acceptance is legal; it is not sampled.
- Arithmetic: the count ranges 0…`WIDTH`. `WIDTH`=8 with `8'hFF` gives 8.

## Timing
- Reset values (`srst_i`=1 sampled at a clock edge):
  - state `IDLE`
  - `res_val_o`=0, `res_data_o`=0, `res_id_o`=0
  - `req_rdy_o`=0 during reset
  - `last`=`REQ_N-1`, so requester 0 has highest priority after reset
- Reset mid-operation (in `CALC` or `DONE`): the pending result is discarded and no `res_val_o` is produced for it.
- Latency: transfer accepted at edge t → `res_val_o`=1 from edge t+2.
- Throughput without the macro: one word per 3 cycles when `res_rdy_i`=1.
- `res_val_o`=1 with `res_rdy_i`=1 at the same edge completes the result. `res_val_o` falls at the next edge unless a back-to-back result follows.
- `req_rdy_o` depends combinationally on `req_val_i`, state and `last`. It never depends on `res_rdy_i` unless the macro is defined.

## Configuration
- `BIT_COUNT_ARB_B2B_EN` defined:
  - In `DONE` with `res_rdy_i`=1, the arbiter also grants a pending request in the same cycle and goes directly to `CALC`.
  - Steady-state throughput becomes one word per 2 cycles.
  - `req_rdy_o` may then depend combinationally on `res_rdy_i`.
- Not defined: behaviour is exactly as in Operation; `DONE` always returns to `IDLE`.

## Structure
- Package `bit_count_arb_pkg`:
  - state enum `arb_state_t` (`IDLE`, `CALC`, `DONE`)
  - function `rr_next(last, val)` returning the winner index, shared with the bench model
- Width localparams stay in the module because they depend on `WIDTH` and `REQ_N`.
- Sub-module `bit_count_core`: registered popcount with `en_i`, 1-cycle latency, output width `$clog2(WIDTH)+2`. It holds its output when `en_i`=0.

## Test plan
- Single request, `WIDTH`=8, `REQ_N`=4: requester 0 sends `8'hFF`, accepted at t → `res_val_o` at t+2 with `res_data_o`=8, `res_id_o`=0.
- All four requesters valid after reset with `8'h01`, `8'h03`, `8'h07`, `8'h0F`, `res_rdy_i`=1 → results in ID order 0,1,2,3 with counts 1,2,3,4, spaced 3 cycles apart (2 apart with the macro).
- Back-pressure: `res_rdy_i`=0 for 5 cycles in `DONE` → `res_val_o`, data and ID stable; `req_rdy_o`=0 throughout.
- Fairness: requesters 0 and 2 continuously valid → grants alternate 0,2,0,2; requesters 1 and 3 are never granted.
- Reset asserted in `CALC` for one cycle → no result emitted. After release, with all four valid, requester 0 wins first.
- Zero word: requester 3 sends `8'h00` → `res_data_o`=0, `res_id_o`=3.

Source files
------------

// File: rtl/bit_count_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_count_arb_pkg
// Description : Shared types and helpers for the bit-count arbiter block.
//               - arb_state_t : arbiter FSM state encoding (IDLE, CALC, DONE)
//               - rr_next     : round-robin winner search, starting after 'last'
// Revision    : 1.0 - initial release
// ============================================================================
package bit_count_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    // Upper bound on the requester count that rr_next can search.
    localparam int unsigned RR_MAX_N = 32;

    // Returns the first requester with its valid bit set, searching
    // last+1, last+2, ... modulo n. Returns 'last' when nothing is valid.
    // The loop has a constant bound so it unrolls cleanly in hardware.
    function automatic int unsigned rr_next(
        input int unsigned          last,
        input logic [RR_MAX_N-1:0]  val,
        input int unsigned          n
    );
        int unsigned idx;
        logic        found;
        rr_next = last;
        found   = 1'b0;
        for (int unsigned i = 1; i <= RR_MAX_N; i++) begin
            if (i <= n && !found) begin
                // last < n and i <= n, so a single subtraction wraps.
                idx = last + i;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (val[idx[4:0]]) begin
                    rr_next = idx;
                    found   = 1'b1;
                end
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_count_core.sv
`default_nettype none
// ============================================================================
// Module      : bit_count_core
// Description : Registered popcount with enable. One cycle of latency; the
//               output holds its value while en_i is low.
// Ports       : clk_i    - clock
//               srst_i   - synchronous active-high reset (clears count)
//               en_i     - register a new count this cycle
//               data_i   - WIDTH-bit word to count
//               count_o  - number of ones, $clog2(WIDTH)+2 bits
// Revision    : 1.0 - initial release
// ============================================================================
module bit_count_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      en_i,
    input  logic [WIDTH-1:0]          data_i,
    output logic [$clog2(WIDTH)+1:0]  count_o
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 2;

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            count_d = count_d + CNT_W'(data_i[i]);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/bit_count_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bit_count_arbiter
// Description : Round-robin front end sharing one popcount core between
//               REQ_N requesters. The winning word is latched in IDLE,
//               counted in CALC, and presented in DONE until res_rdy_i.
// Ports       : clk_i      - clock
//               srst_i     - synchronous active-high reset
//               req_val_i  - per-requester valid
//               req_data_i - requester k word in [k*WIDTH +: WIDTH]
//               req_rdy_o  - one-hot accept (combinational)
//               res_val_o  - result valid
//               res_data_o - popcount of the accepted word
//               res_id_o   - requester index of the result
//               res_rdy_i  - consumer accepts the result
// Config      : BIT_COUNT_ARB_B2B_EN - when defined, DONE with res_rdy_i
//               also grants a pending request and goes straight to CALC.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_count_arbiter
    import bit_count_arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned REQ_N = 4
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic [REQ_N-1:0]          req_val_i,
    input  logic [REQ_N*WIDTH-1:0]    req_data_i,
    output logic [REQ_N-1:0]          req_rdy_o,
    output logic                      res_val_o,
    output logic [$clog2(WIDTH)+1:0]  res_data_o,
    output logic [$clog2(REQ_N)-1:0]  res_id_o,
    input  logic                      res_rdy_i
);

    localparam int unsigned ID_W  = $clog2(REQ_N);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 2;

    arb_state_t        state_q;
    logic [ID_W-1:0]   last_q;
    logic [ID_W-1:0]   id_q;
    logic [WIDTH-1:0]  data_q;
    logic              res_val_q;

    logic [WIDTH-1:0]  w_words [REQ_N];
    logic [ID_W-1:0]   w_win;
    logic              w_grant_en;
    logic              w_take;
    logic [CNT_W-1:0]  w_count;

    genvar gi;
    generate
        for (gi = 0; gi < int'(REQ_N); gi++) begin : g_words
            assign w_words[gi] = req_data_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_win = ID_W'(rr_next(32'(last_q), RR_MAX_N'(req_val_i), REQ_N));

    // Grant window: IDLE always; DONE only while the result is being taken
    // when back-to-back operation is enabled. Reset masks every grant.
    always_comb begin
        w_grant_en = 1'b0;
        if (!srst_i) begin
            if (state_q == IDLE) begin
                w_grant_en = 1'b1;
            end
`ifdef BIT_COUNT_ARB_B2B_EN
            if (state_q == DONE && res_rdy_i) begin
                w_grant_en = 1'b1;
            end
`endif
        end
    end

    assign w_take    = w_grant_en & (|req_val_i);
    assign req_rdy_o = w_take ? (REQ_N'(1) << w_win) : '0;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q   <= IDLE;
            last_q    <= ID_W'(REQ_N - 1);
            id_q      <= '0;
            data_q    <= '0;
            res_val_q <= 1'b0;
        end else begin
            if (w_take) begin
                data_q <= w_words[w_win];
                id_q   <= w_win;
                last_q <= w_win;
            end
            case (state_q)
                IDLE: begin
                    if (w_take) begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    state_q   <= DONE;
                    res_val_q <= 1'b1;
                end
                DONE: begin
                    if (res_rdy_i) begin
                        res_val_q <= 1'b0;
`ifdef BIT_COUNT_ARB_B2B_EN
                        state_q   <= w_take ? CALC : IDLE;
`else
                        state_q   <= IDLE;
`endif
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    bit_count_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .en_i    (state_q == CALC),
        .data_i  (data_q),
        .count_o (w_count)
    );

    assign res_val_o  = res_val_q;
    assign res_data_o = w_count;
    // id_q only changes on a grant, which never happens while a result is
    // being held, so it can drive the output directly.
    assign res_id_o   = id_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_count_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_count_arbiter
// Description : Self-checking bench for bit_count_arbiter with a
//               transaction-level model (grant order, latency, hold rules).
// Config      : BIT_COUNT_ARB_B2B_EN - selects the back-to-back expectations
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bit_count_arbiter;
    import bit_count_arb_pkg::*;

    localparam int WIDTH = 8;
    localparam int REQ_N = 4;
`ifdef BIT_COUNT_ARB_B2B_EN
    localparam int SPACING = 2;
`else
    localparam int SPACING = 3;
`endif

    logic                clk = 1'b0;
    logic                srst;
    logic [REQ_N-1:0]    req_val;
    logic [REQ_N*8-1:0]  req_data;
    logic [REQ_N-1:0]    req_rdy;
    logic                res_val;
    logic [4:0]          res_data;
    logic [1:0]          res_id;
    logic                res_rdy;

    bit_count_arbiter #(.WIDTH(WIDTH), .REQ_N(REQ_N)) dut (
        .clk_i      (clk),
        .srst_i     (srst),
        .req_val_i  (req_val),
        .req_data_i (req_data),
        .req_rdy_o  (req_rdy),
        .res_val_o  (res_val),
        .res_data_o (res_data),
        .res_id_o   (res_id),
        .res_rdy_i  (res_rdy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct { int id; int cnt; int due; } res_t;
    res_t  r_log[$];
    int    g_log[$];
    int    cyc    = 0;
    bit    m_busy = 0;
    int    m_id, m_cnt, m_due;
    int    m_last = REQ_N - 1;
    logic [REQ_N-1:0] acc_dut = '0;
    logic [REQ_N-1:0] refill  = '0;

    always @(posedge clk) cyc++;

    // Expected behaviour: one word in flight; result visible two edges
    // after acceptance and held until taken; grants go to the first valid
    // requester after the last one granted.
    always @(negedge clk) begin : model
        logic [REQ_N-1:0] exp_rdy;
        bit ev;
        int w, idx;
        exp_rdy = '0;
        ev = m_busy && (cyc >= m_due);
        w  = -1;
        for (int k = 1; k <= REQ_N; k++) begin
            idx = (m_last + k) % REQ_N;
            if (w < 0 && req_val[idx]) w = idx;
        end
        if (!srst && w >= 0) begin
            if (!m_busy) exp_rdy = REQ_N'(1) << w;
`ifdef BIT_COUNT_ARB_B2B_EN
            else if (ev && res_rdy) exp_rdy = REQ_N'(1) << w;
`endif
        end
        chk("req_rdy", 32'(req_rdy), 32'(exp_rdy));
        chk("res_val", 32'(res_val), 32'(ev));
        if (ev) begin
            chk("res_data", 32'(res_data), 32'(m_cnt));
            chk("res_id", 32'(res_id), 32'(m_id));
        end
        acc_dut = req_val & req_rdy;
        if (srst) begin
            m_busy = 0;
            m_last = REQ_N - 1;
        end else begin
            if (ev && res_rdy) begin
                r_log.push_back('{id: m_id, cnt: m_cnt, due: m_due});
                m_busy = 0;
            end
            if (exp_rdy != 0) begin
                m_busy = 1;
                m_id   = w;
                m_cnt  = $countones(req_data[w*8 +: 8]);
                m_due  = cyc + 2;
                m_last = w;
                g_log.push_back(w);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance one cycle; requesters whose word was taken either drop valid
    // or (refill) present a fresh word.
    task automatic step();
        @(posedge clk);
        #1;
        for (int k = 0; k < REQ_N; k++) begin
            if (acc_dut[k]) begin
                if (refill[k]) req_data[k*8 +: 8] = 8'($urandom);
                else req_val[k] = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        srst = 1'b1; req_val = '0; refill = '0;
        step(); step();
        srst = 1'b0;
    endtask

    task automatic wait_res(input int n, input int budget, input string nm);
        int i = 0;
        while (r_log.size() < n && i < budget) begin step(); i++; end
        chk(nm, 32'(r_log.size() >= n), 32'd1);
    endtask

    task automatic drain();
        req_val = '0; refill = '0; res_rdy = 1'b1;
        repeat (8) step();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base, gbase, i;
        logic [4:0] hd;
        logic [1:0] hi;
        srst = 1'b1; req_val = '0; req_data = '0; res_rdy = 1'b1;

        // rr_next pinned by hand
        chk("rr_next_a", rr_next(3, 32'b0101, 4), 32'd0);
        chk("rr_next_b", rr_next(0, 32'b0101, 4), 32'd2);
        chk("rr_next_c", rr_next(2, 32'b1000, 4), 32'd3);

        // reset values, with requests present during reset
        step(); step();
        req_val = 4'hF; req_data = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("rst_res_val", 32'(res_val), 0);
        chk("rst_res_data", 32'(res_data), 0);
        chk("rst_res_id", 32'(res_id), 0);
        chk("rst_req_rdy", 32'(req_rdy), 0);
        req_val = '0;

        // single request, all ones
        step(); srst = 1'b0;
        req_val = 4'b0001; req_data = 32'h0000_00FF;
        base = r_log.size();
        wait_res(base + 1, 20, "t1_done");
        chk("t1_id", r_log[base].id, 0);
        chk("t1_cnt", r_log[base].cnt, 8);
        drain();

        // four requesters after reset, in ID order
        do_reset();
        req_val = 4'hF; req_data = 32'h0F07_0301;
        base = r_log.size();
        wait_res(base + 4, 40, "t2_done");
        for (int k = 0; k < 4; k++) begin
            chk("t2_id", r_log[base+k].id, k);
            chk("t2_cnt", r_log[base+k].cnt, k + 1);
            if (k > 0) chk("t2_spacing", r_log[base+k].due - r_log[base+k-1].due, SPACING);
        end
        drain();

        // back-pressure (last granted = 3, so requester 1 wins first)
        res_rdy = 1'b0;
        req_val = 4'b0110; req_data = 32'h003C_A500;
        base = r_log.size();
        i = 0;
        while (res_val !== 1'b1 && i < 10) begin step(); i++; end
        chk("t3_val_seen", 32'(res_val), 1);
        hd = res_data; hi = res_id;
        chk("t3_data", 32'(hd), 4);
        chk("t3_id", 32'(hi), 1);
        repeat (5) begin
            step();
            @(negedge clk);
            chk("t3_hold_val", 32'(res_val), 1);
            chk("t3_hold_data", 32'(res_data), 32'(hd));
            chk("t3_hold_id", 32'(res_id), 32'(hi));
            chk("t3_hold_rdy", 32'(req_rdy), 0);
        end
        res_rdy = 1'b1;
        wait_res(base + 2, 20, "t3_done");
        chk("t3_second_id", r_log[base+1].id, 2);
        chk("t3_second_cnt", r_log[base+1].cnt, 4);
        drain();

        // fairness between 0 and 2
        do_reset();
        refill = 4'b0101; req_val = 4'b0101; req_data = $urandom;
        gbase = g_log.size();
        i = 0;
        while (g_log.size() < gbase + 6 && i < 40) begin step(); i++; end
        chk("t4_grants", 32'(g_log.size() >= gbase + 6), 1);
        for (int k = 0; k < 6 && gbase + k < g_log.size(); k++)
            chk("t4_order", g_log[gbase+k], (k % 2 == 0) ? 0 : 2);
        drain();

        // reset while in CALC
        do_reset();
        req_val = 4'hF; req_data = 32'h8421_1248;
        step();
        chk("t5_accept", 32'(acc_dut), 32'b0001);
        srst = 1'b1;
        base = r_log.size();
        step();
        srst = 1'b0;
        req_val[0] = 1'b1;
        gbase = g_log.size();
        chk("t5_no_result", r_log.size(), base);
        i = 0;
        while (g_log.size() <= gbase && i < 10) begin step(); i++; end
        chk("t5_regrant", 32'(g_log.size() > gbase), 1);
        if (g_log.size() > gbase) chk("t5_first", g_log[gbase], 0);
        drain();

        // zero word from requester 3
        req_val = 4'b1000; req_data = 32'h0000_0000;
        base = r_log.size();
        wait_res(base + 1, 20, "t6_done");
        chk("t6_id", r_log[base].id, 3);
        chk("t6_cnt", r_log[base].cnt, 0);
        drain();

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step();
            srst = ($urandom_range(0, 299) == 0);
            res_rdy = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < REQ_N; k++) begin
                if (!req_val[k] && $urandom_range(0, 3) == 0) begin
                    req_val[k] = 1'b1;
                    case ($urandom_range(0, 5))
                        0: req_data[k*8 +: 8] = 8'hFF;
                        1: req_data[k*8 +: 8] = 8'h00;
                        default: req_data[k*8 +: 8] = 8'($urandom);
                    endcase
                end else if (req_val[k] && $urandom_range(0, 15) == 0) begin
                    req_val[k] = 1'b0;
                end
            end
        end
        srst = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
